// File: rtl/monitor_secuencia_if.sv
// Signal bundle between a counter under observation and its sequence monitor.
// There is no valid/ready handshake: Q is sampled on every rising clock edge,
// and every monitor output is registered and valid one cycle after that edge.
interface monitor_secuencia_if;
  logic [3:0] Q;
  logic       LOCK;
  logic       ERR;
  logic       WRAP;
  logic [2:0] IDX;
  logic [7:0] NERR;
  logic       TRACK_DBG;

  modport master (output Q, input LOCK, ERR, WRAP, IDX, NERR, TRACK_DBG);
  modport slave  (input Q, output LOCK, ERR, WRAP, IDX, NERR, TRACK_DBG);
endinterface

// File: rtl/monitor_secuencia.sv
// Watches a 4-bit counter and checks that it steps through a fixed cyclic sequence,
// flagging violations, counting them (saturating) and marking each full cycle.
module monitor_secuencia #(
  parameter int         LEN = 8,
  parameter logic [3:0] S0  = 4'd0,
  parameter logic [3:0] S1  = 4'd1,
  parameter logic [3:0] S2  = 4'd3,
  parameter logic [3:0] S3  = 4'd7,
  parameter logic [3:0] S4  = 4'd15,
  parameter logic [3:0] S5  = 4'd14,
  parameter logic [3:0] S6  = 4'd12,
  parameter logic [3:0] S7  = 4'd8
) (
  input logic               C,
  input logic               R,
  monitor_secuencia_if.slave mon
);

  typedef enum logic {ACQUIRE, TRACK} state_t;

  localparam logic [3:0] SEQ [8] = '{S0, S1, S2, S3, S4, S5, S6, S7};

  state_t     state_q, state_d;
  logic       lock_q, lock_d;
  logic       err_q, err_d;
  logic       wrap_q, wrap_d;
  logic [2:0] idx_q, idx_d;
  logic [7:0] nerr_q, nerr_d;

  logic       hit;
  logic [2:0] hit_idx;
  logic [2:0] idx_nxt;
  logic       advance;

  always_comb begin
    // Scan downward so the lowest matching index wins; entries past LEN are skipped.
    hit     = 1'b0;
    hit_idx = 3'd0;
    for (int k = 7; k >= 0; k--) begin
      if (k < LEN && mon.Q == SEQ[k]) begin
        hit     = 1'b1;
        hit_idx = 3'(k);
      end
    end
    idx_nxt = (idx_q == 3'(LEN - 1)) ? 3'd0 : idx_q + 3'd1;
    // A repeated sample is never progress, even if it also equals the next entry.
    advance = (mon.Q == SEQ[idx_nxt]) && (mon.Q != SEQ[idx_q]);

    state_d = state_q;
    lock_d  = lock_q;
    idx_d   = idx_q;
    nerr_d  = nerr_q;
    err_d   = 1'b0;
    wrap_d  = 1'b0;

    case (state_q)
      ACQUIRE: begin
        if (hit) begin
          state_d = TRACK;
          idx_d   = hit_idx;
          lock_d  = 1'b1;
        end else begin
          lock_d  = 1'b0;
        end
      end
      TRACK: begin
        if (advance) begin
          idx_d  = idx_nxt;
          wrap_d = (idx_nxt == 3'd0);
        end else begin
          state_d = ACQUIRE;
          lock_d  = 1'b0;
          err_d   = 1'b1;
          nerr_d  = (nerr_q == 8'hFF) ? nerr_q : nerr_q + 8'd1;
        end
      end
      default: state_d = ACQUIRE;
    endcase
  end

  always_ff @(posedge C) begin
    if (R) begin
      state_q <= ACQUIRE;
      lock_q  <= 1'b0;
      err_q   <= 1'b0;
      wrap_q  <= 1'b0;
      idx_q   <= 3'd0;
      nerr_q  <= 8'd0;
    end else begin
      state_q <= state_d;
      lock_q  <= lock_d;
      err_q   <= err_d;
      wrap_q  <= wrap_d;
      idx_q   <= idx_d;
      nerr_q  <= nerr_d;
    end
  end

  assign mon.LOCK      = lock_q;
  assign mon.ERR       = err_q;
  assign mon.WRAP      = wrap_q;
  assign mon.IDX       = idx_q;
  assign mon.NERR      = nerr_q;
  assign mon.TRACK_DBG = (state_q == TRACK);

endmodule

// File: tb/tb_monitor_secuencia.sv
// Bench for monitor_secuencia: an 8-entry and a 4-entry instance share stimulus
// and are checked against a behavioural model of the sequence rules.
module tb_monitor_secuencia;

  logic C = 1'b0;
  logic R = 1'b1;

  int n_vec  = 0;
  int n_fail = 0;

  monitor_secuencia_if mi8 ();
  monitor_secuencia_if mi4 ();

  monitor_secuencia #(.LEN(8)) dut8 (.C(C), .R(R), .mon(mi8.slave));
  monitor_secuencia #(.LEN(4)) dut4 (.C(C), .R(R), .mon(mi4.slave));

  // Clock and reset
  always #5 C = ~C;

  // Reference model: index 0 is the LEN=8 instance, index 1 the LEN=4 one
  int seqv [8] = '{0, 1, 3, 7, 15, 14, 12, 8};
  int lenv [2] = '{8, 4};
  int m_idx [2];
  int m_nerr [2];
  bit m_lock [2];
  bit m_err [2];
  bit m_wrap [2];
  bit m_trk [2];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic model_edge(input int i, input bit r, input int q);
    int nxt;
    int found;
    m_err[i]  = 0;
    m_wrap[i] = 0;
    if (r) begin
      m_trk[i] = 0; m_lock[i] = 0; m_idx[i] = 0; m_nerr[i] = 0;
    end else if (!m_trk[i]) begin
      found = -1;
      for (int k = lenv[i] - 1; k >= 0; k--)
        if (seqv[k] == q) found = k;
      if (found >= 0) begin
        m_trk[i] = 1; m_lock[i] = 1; m_idx[i] = found;
      end else begin
        m_lock[i] = 0;
      end
    end else begin
      nxt = (m_idx[i] + 1) % lenv[i];
      if (q == seqv[nxt] && q != seqv[m_idx[i]]) begin
        m_wrap[i] = (nxt == 0);
        m_idx[i]  = nxt;
      end else begin
        m_err[i]  = 1;
        m_lock[i] = 0;
        m_trk[i]  = 0;
        m_nerr[i] = (m_nerr[i] >= 255) ? 255 : m_nerr[i] + 1;
      end
    end
  endtask

  task automatic cmp_outputs();
    chk("lock8", mi8.LOCK, m_lock[0]);
    chk("err8",  mi8.ERR,  m_err[0]);
    chk("wrap8", mi8.WRAP, m_wrap[0]);
    chk("idx8",  mi8.IDX,  m_idx[0]);
    chk("nerr8", mi8.NERR, m_nerr[0]);
    chk("trk8",  mi8.TRACK_DBG, m_trk[0]);
    chk("lock4", mi4.LOCK, m_lock[1]);
    chk("err4",  mi4.ERR,  m_err[1]);
    chk("wrap4", mi4.WRAP, m_wrap[1]);
    chk("idx4",  mi4.IDX,  m_idx[1]);
    chk("nerr4", mi4.NERR, m_nerr[1]);
    chk("trk4",  mi4.TRACK_DBG, m_trk[1]);
  endtask

  // Driver: apply one sample to both instances, then check one step after the edge
  task automatic step(input bit r, input int q);
    R     = r;
    mi8.Q = 4'(q);
    mi4.Q = 4'(q);
    @(posedge C);
    model_edge(0, r, q);
    model_edge(1, r, q);
    #1;
    cmp_outputs();
  endtask

  task automatic run_list(input int lst [$]);
    foreach (lst[k]) step(0, lst[k]);
  endtask

  initial begin
    int q;
    mi8.Q = 4'd0;
    mi4.Q = 4'd0;

    // Full cycle with wrap
    step(1, 9);
    run_list('{0, 1, 3, 7, 15, 14, 12, 8, 0});
    chk("wrap_full8", mi8.WRAP, 1);

    // Jump 3 -> 15, then reacquire on 14
    step(1, 0);
    run_list('{0, 1, 3, 15, 14});
    chk("reacq_idx8", mi8.IDX, 5);

    // Out-of-sequence value never locks, then 7 locks at index 3
    step(1, 0);
    run_list('{5, 5, 5, 5, 7});
    chk("acq_idx8", mi8.IDX, 3);

    // Held value is a violation
    step(1, 0);
    run_list('{0, 1, 1});
    chk("hold_nerr8", mi8.NERR, 1);

    // Saturation of the violation counter
    step(1, 0);
    for (int n = 0; n < 300; n++) begin
      step(0, 0);
      step(0, 0);
    end
    chk("sat_nerr8", mi8.NERR, 255);
    step(0, 0);
    step(0, 1);
    step(1, 3);
    chk("rst_lock8", mi8.LOCK, 0);
    chk("rst_nerr8", mi8.NERR, 0);

    // Short sequence wrap and violation
    step(1, 0);
    run_list('{0, 1, 3, 7, 0});
    chk("wrap_len4", mi4.WRAP, 1);
    step(0, 15);
    chk("err_len4", mi4.ERR, 1);

    // Randomized phase, biased toward the 8-entry instance's expected next value
    for (int n = 0; n < 3000; n++) begin
      if (m_trk[0] && $urandom_range(0, 99) < 80)
        q = seqv[(m_idx[0] + 1) % 8];
      else if ($urandom_range(0, 99) < 30)
        q = seqv[$urandom_range(0, 7)];
      else
        q = int'($urandom_range(0, 15));
      step($urandom_range(0, 99) == 0, q);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule
